// File: rtl/servo_pkg.sv
// servo_pkg: shared types and constants for the multi-channel servo pulse generator.
//   mode_e      : frame-load source selection (direct / sweep / centre / direct)
//   pos_t       : 8-bit servo position
//   width_t     : 16-bit pulse width in microseconds
//   pulse_width : MIN_US + pos*STEP_US, unsigned, truncated to 16 bits
package servo_pkg;

   localparam int unsigned POS_W = 8;

   typedef logic [POS_W-1:0] pos_t;
   typedef logic [15:0]      width_t;

   localparam pos_t POS_CENTRE = 8'd128;

   typedef enum logic [1:0] {
      MODE_DIRECT     = 2'd0,
      MODE_SWEEP      = 2'd1,
      MODE_CENTRE     = 2'd2,
      MODE_DIRECT_ALT = 2'd3
   } mode_e;

   function automatic width_t pulse_width(input pos_t pos,
                                          input int unsigned min_us,
                                          input int unsigned step_us);
      return width_t'(min_us) + width_t'(pos) * width_t'(step_us);
   endfunction

endpackage

// File: rtl/servo_chan.sv
// servo_chan: one servo output channel.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : frame load strobe (active position <= src_i)
//   src_i      : position selected for the next frame
//   run_i      : a frame is in progress and the block is enabled
//   elapsed_i  : microseconds elapsed since the current frame started
//   pwm_o      : servo pulse, high while elapsed_i < pulse width
module servo_chan
   import servo_pkg::*;
#(
   parameter int unsigned MIN_US  = 1000,
   parameter int unsigned STEP_US = 4,
   parameter int unsigned FCW     = 15
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load_i,
   input  pos_t           src_i,
   input  logic           run_i,
   input  logic [FCW-1:0] elapsed_i,
   output logic           pwm_o
);

   pos_t   active_q, active_d;
   width_t width;

   always_comb begin
      active_d = active_q;
      if (load_i) active_d = src_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) active_q <= POS_CENTRE;
      else        active_q <= active_d;
   end

   assign width = pulse_width(active_q, MIN_US, STEP_US);
   assign pwm_o = run_i && (32'(elapsed_i) < 32'(width));

endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: NUM_CH servo pulse generators sharing one frame timer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   ena         : block enable; low holds the timer and forces outputs low
//   pos_in      : position written to shadow[ch_sel] on a strobe edge
//   ch_sel      : write target; values >= NUM_CH are ignored
//   wr_strobe   : asynchronous write strobe, rising edge writes
//   mode        : 0/3 direct, 1 sweep, 2 centre; sampled at frame load
//   pwm_out     : one servo pulse per channel
//   frame_start : one-cycle pulse at the start of every frame
module servo_pwm_multi
   import servo_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 10_000_000,
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned FRAME_US = 20000,
   parameter int unsigned MIN_US   = 1000,
   parameter int unsigned STEP_US  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [7:0]        pos_in,
   input  logic [2:0]        ch_sel,
   input  logic              wr_strobe,
   input  logic [1:0]        mode,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              frame_start
);

   localparam int unsigned PRESC = CLK_HZ / 1_000_000;
   localparam int unsigned PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam int unsigned FCW   = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

   logic [PW-1:0]  presc_q, presc_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic [FCW-1:0] elapsed;
   logic           live_q;
   logic           run_q, run_d;
   logic           us_tick;
   logic [2:0]     sync_q;
   logic           wr_edge;
   pos_t           shadow_q [NUM_CH];
   pos_t           shadow_d [NUM_CH];
   pos_t           sweep_q, sweep_d;
   logic           dir_up_q, dir_up_d;

   // live_q keeps the tick quiet while reset is held when PRESC is 1
   // (the prescaler then sits at its terminal count permanently).
   assign us_tick     = ena && live_q && (presc_q == PW'(PRESC - 1));
   assign frame_start = us_tick && (fcnt_q == '0);

   // Counter value 0 spans the last microsecond of the previous frame, so
   // the elapsed time of the running frame is fcnt-1, or FRAME_US-1 at 0.
   assign elapsed = (fcnt_q == '0) ? FCW'(FRAME_US - 1) : fcnt_q - FCW'(1);

   assign wr_edge = sync_q[1] && !sync_q[2];

   always_comb begin
      presc_d  = presc_q;
      fcnt_d   = fcnt_q;
      run_d    = ena && (run_q || frame_start);
      sweep_d  = sweep_q;
      dir_up_d = dir_up_q;
      shadow_d = shadow_q;

      if (!ena) begin
         presc_d = '0;
         fcnt_d  = '0;
      end else begin
         presc_d = us_tick ? '0 : presc_q + PW'(1);
         if (us_tick)
            fcnt_d = (fcnt_q == FCW'(FRAME_US - 1)) ? '0 : fcnt_q + FCW'(1);
      end

      if (frame_start) begin
         sweep_d = dir_up_q ? sweep_q + pos_t'(1) : sweep_q - pos_t'(1);
         if (sweep_d == '1)      dir_up_d = 1'b0;
         else if (sweep_d == '0) dir_up_d = 1'b1;
      end

      for (int unsigned i = 0; i < NUM_CH; i++)
         if (wr_edge && (ch_sel == 3'(i))) shadow_d[i] = pos_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q  <= '0;
         fcnt_q   <= '0;
         live_q   <= 1'b0;
         run_q    <= 1'b0;
         sync_q   <= '0;
         sweep_q  <= '0;
         dir_up_q <= 1'b1;
         for (int unsigned i = 0; i < NUM_CH; i++) shadow_q[i] <= POS_CENTRE;
      end else begin
         presc_q  <= presc_d;
         fcnt_q   <= fcnt_d;
         live_q   <= 1'b1;
         run_q    <= run_d;
         sync_q   <= {sync_q[1:0], wr_strobe};
         sweep_q  <= sweep_d;
         dir_up_q <= dir_up_d;
         shadow_q <= shadow_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      pos_t src;

      always_comb begin
         case (mode_e'(mode))
            MODE_SWEEP:  src = sweep_q;
            MODE_CENTRE: src = POS_CENTRE;
            default:     src = shadow_q[g];
         endcase
      end

      servo_chan #(
         .MIN_US (MIN_US),
         .STEP_US(STEP_US),
         .FCW    (FCW)
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .load_i   (frame_start),
         .src_i    (src),
         .run_i    (run_q && ena),
         .elapsed_i(elapsed),
         .pwm_o    (pwm_out[g])
      );
   end

endmodule

// File: tb/tb_servo_pwm_multi.sv
module tb_servo_pwm_multi;

   localparam int NCH      = 4;
   localparam int CLK_HZ   = 2_000_000;
   localparam int FRAME_US = 600;
   localparam int MIN_US   = 100;
   localparam int STEP_US  = 2;
   localparam int P        = CLK_HZ / 1_000_000;
   localparam int FP       = FRAME_US * P;

   // second instance: long sweep run, 1 MHz clock, width in us == position
   localparam int S_FRAME  = 256;
   localparam int S_RUN    = 262;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           rst1_n = 1'b0;
   logic           ena = 1'b0;
   logic [7:0]     pos_in = '0;
   logic [2:0]     ch_sel = '0;
   logic           wr_strobe = 1'b0;
   logic [1:0]     mode = '0;
   logic [NCH-1:0] pwm_out;
   logic           frame_start;
   logic [1:0]     pwm1;
   logic           fs1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   servo_pwm_multi #(
      .CLK_HZ  (CLK_HZ),
      .NUM_CH  (NCH),
      .FRAME_US(FRAME_US),
      .MIN_US  (MIN_US),
      .STEP_US (STEP_US)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .pos_in     (pos_in),
      .ch_sel     (ch_sel),
      .wr_strobe  (wr_strobe),
      .mode       (mode),
      .pwm_out    (pwm_out),
      .frame_start(frame_start)
   );

   servo_pwm_multi #(
      .CLK_HZ  (1_000_000),
      .NUM_CH  (2),
      .FRAME_US(S_FRAME),
      .MIN_US  (0),
      .STEP_US (1)
   ) dut_sweep (
      .clk        (clk),
      .rst_n      (rst1_n),
      .ena        (1'b1),
      .pos_in     (8'd0),
      .ch_sel     (3'd0),
      .wr_strobe  (1'b0),
      .mode       (2'd1),
      .pwm_out    (pwm1),
      .frame_start(fs1)
   );

   // ---------------- reference model ----------------
   function automatic int tri_pos(input int n);
      int r;
      r = n % 510;
      return (r <= 255) ? r : 510 - r;
   endfunction

   function automatic int high_cycles(input int pos, input int min_us, input int step_us,
                                      input int frame_us, input int p);
      int w;
      w = (min_us + pos * step_us) % 65536;
      if (w > frame_us) w = frame_us;
      return w * p;
   endfunction

   typedef struct packed { int due; int ch; int pos; } wr_t;

   wr_t pend[$];
   int  exp_q[$];
   int  q1[$];
   int  m_shadow[NCH];
   int  m_t;
   int  m_nfs;
   bit  m_fs;

   always @(negedge clk) begin
      m_fs = 1'b0;
      if (!rst_n) begin
         m_t   = 0;
         m_nfs = 0;
         foreach (m_shadow[i]) m_shadow[i] = 128;
         pend.delete();
         exp_q.delete();
      end else begin
         if (!ena) begin
            m_t = 0;
            exp_q.delete();
         end else begin
            if (m_t % FP == P - 1) begin
               m_fs = 1'b1;
               for (int i = 0; i < NCH; i++) begin
                  int src;
                  if (mode == 2'd1)      src = tri_pos(m_nfs);
                  else if (mode == 2'd2) src = 128;
                  else                   src = m_shadow[i];
                  exp_q.push_back(high_cycles(src, MIN_US, STEP_US, FRAME_US, P));
               end
               m_nfs++;
            end
            m_t++;
         end
         // writes land after the frame load of the same cycle
         for (int k = pend.size() - 1; k >= 0; k--) begin
            if (pend[k].due == cyc) begin
               if (pend[k].ch < NCH) m_shadow[pend[k].ch] = pend[k].pos;
               pend.delete(k);
            end
         end
      end
   end

   // ---------------- monitors ----------------
   int cnt[NCH];
   bit in_frame = 1'b0;

   always @(negedge clk) begin
      #1;
      if (!rst_n || !ena) begin
         in_frame = 1'b0;
         foreach (cnt[i]) cnt[i] = 0;
         checks++;
         if (pwm_out !== '0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_out pwm=%b fs=%b required 0/0 at cyc %0d", pwm_out, frame_start, cyc);
         end
      end else begin
         for (int i = 0; i < NCH; i++) if (pwm_out[i] === 1'b1) cnt[i]++;
         if (frame_start !== 1'b0 || m_fs) begin
            checks++;
            if (frame_start !== m_fs) begin
               errors++;
               $display("FAIL frame_start_time got %b required %b at cyc %0d", frame_start, m_fs, cyc);
            end
         end
         if (frame_start === 1'b1) begin
            if (in_frame) begin
               for (int i = 0; i < NCH; i++) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++;
                     $display("FAIL width_ch%0d got %0d required <none queued> at cyc %0d", i, cnt[i], cyc);
                  end else begin
                     int e;
                     e = exp_q.pop_front();
                     if (cnt[i] != e) begin
                        errors++;
                        $display("FAIL width_ch%0d got %0d cycles required %0d at cyc %0d", i, cnt[i], e, cyc);
                     end
                  end
               end
            end
            in_frame = 1'b1;
            foreach (cnt[i]) cnt[i] = 0;
         end
      end
   end

   int c1[2];
   int per1 = 0;
   int n1_done = 0;
   bit in1 = 1'b0;

   always @(negedge clk) begin
      #1;
      if (!rst1_n) begin
         in1 = 1'b0;
         per1 = 0;
         foreach (c1[i]) c1[i] = 0;
      end else begin
         per1++;
         for (int i = 0; i < 2; i++) if (pwm1[i] === 1'b1) c1[i]++;
         if (fs1 === 1'b1) begin
            if (in1) begin
               int e;
               checks++;
               if (per1 != S_FRAME) begin
                  errors++;
                  $display("FAIL sweep_period got %0d required %0d", per1, S_FRAME);
               end
               e = (q1.size() > 0) ? q1.pop_front() : -1;
               for (int i = 0; i < 2; i++) begin
                  checks++;
                  if (c1[i] != e) begin
                     errors++;
                     $display("FAIL sweep_width_ch%0d frame %0d got %0d required %0d", i, n1_done, c1[i], e);
                  end
               end
               n1_done++;
            end
            in1 = 1'b1;
            per1 = 0;
            foreach (c1[i]) c1[i] = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_write(input int ch, input int pos);
      wr_t w;
      ch_sel    = 3'(ch);
      pos_in    = 8'(pos);
      wr_strobe = 1'b1;
      w.due = cyc + 2;
      w.ch  = ch;
      w.pos = pos;
      pend.push_back(w);
      cycles(4);
      wr_strobe = 1'b0;
      cycles(4);
   endtask

   task automatic wait_mfs();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while (!m_fs && n < 3 * FP);
      if (!m_fs) begin
         errors++;
         checks++;
         $display("FAIL frame_wait no frame start within %0d cycles", 3 * FP);
      end
   endtask

   task automatic frames(input int n);
      repeat (n) wait_mfs();
   endtask

   initial begin
      for (int n = 0; n < S_RUN + 4; n++)
         q1.push_back(high_cycles(tri_pos(n), 0, 1, S_FRAME, 1));

      cycles(5);
      checks++;
      if (pwm_out !== '0 || frame_start !== 1'b0 || pwm1 !== '0 || fs1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_out pwm=%b fs=%b pwm1=%b fs1=%b required all 0", pwm_out, frame_start, pwm1, fs1);
      end
      rst_n  = 1'b1;
      rst1_n = 1'b1;
      ena    = 1'b1;
      frames(3);

      // mid-frame writes take effect from the next frame
      cycles(300);
      do_write(0, 0);
      do_write(3, 255);
      frames(2);

      // out-of-range channels are dropped
      cycles(200);
      do_write(5, 9);
      do_write(4, 3);
      frames(2);

      // write edge coinciding with the frame load: old value this frame
      wait_mfs();
      @(posedge clk);
      repeat (FP - 3) @(posedge clk);
      #1;
      do_write(1, 250);
      frames(2);

      repeat (6) begin
         cycles(int'($urandom_range(10, 700)));
         do_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      end
      frames(1);

      cycles(int'($urandom_range(1, 1000)));
      mode = 2'd2;
      frames(2);
      cycles(int'($urandom_range(1, 1000)));
      mode = 2'd0;
      frames(2);
      cycles(50);
      mode = 2'd1;
      frames(3);
      cycles(50);
      mode = 2'd3;
      frames(2);
      repeat (4) begin
         cycles(int'($urandom_range(1, 1100)));
         mode = 2'($urandom_range(0, 3));
         wait_mfs();
      end
      mode = 2'd0;
      frames(2);

      // disable mid-pulse; writes still land while disabled
      wait_mfs();
      cycles(100);
      checks++;
      if (pwm_out !== '1) begin
         errors++;
         $display("FAIL pre_disable pwm=%b required %b", pwm_out, {NCH{1'b1}});
      end
      ena = 1'b0;
      #1;
      checks++;
      if (pwm_out !== '0) begin
         errors++;
         $display("FAIL ena_off pwm=%b required 0", pwm_out);
      end
      do_write(2, 77);
      cycles(3000);
      ena = 1'b1;
      frames(3);

      // asynchronous reset mid-pulse
      wait_mfs();
      cycles(150);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (pwm_out !== '0) begin
         errors++;
         $display("FAIL rst_async pwm=%b required 0", pwm_out);
      end
      cycles(4);
      rst_n = 1'b1;
      frames(3);

      begin
         int guard;
         guard = 0;
         while (n1_done < S_RUN && guard < 90000) begin
            @(posedge clk);
            guard++;
         end
         checks++;
         if (n1_done < S_RUN) begin
            errors++;
            $display("FAIL sweep_run frames %0d required %0d", n1_done, S_RUN);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
